// File: rtl/mem_pkg.sv
// Shared memory-port widths and the request FSM states, common to the
// external memory model and the processor-side memory subsystem.
package mem_pkg;
  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_TAG_BITS  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } mem_state_e;
endpackage

// File: rtl/ext_mem_model_if.sv
// External memory port: request channel, write-data channel and the
// backpressure-free response channel.
interface ext_mem_model_if import mem_pkg::*; #(
  parameter int DATA_BITS = MEM_DATA_BITS,
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int TAG_BITS  = MEM_TAG_BITS
);
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_rw;
  logic [ADDR_BITS-1:0]   mem_req_addr;
  logic [TAG_BITS-1:0]    mem_req_tag;
  logic                   mem_req_data_valid;
  logic                   mem_req_data_ready;
  logic [DATA_BITS-1:0]   mem_req_data_bits;
  logic [DATA_BITS/8-1:0] mem_req_data_mask;
  logic                   mem_resp_valid;
  logic [TAG_BITS-1:0]    mem_resp_tag;
  logic [DATA_BITS-1:0]   mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready,
           mem_resp_valid, mem_resp_tag, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready,
           mem_resp_valid, mem_resp_tag, mem_resp_data
  );
endinterface

// File: rtl/ext_mem_resp_pipe.sv
// Fixed-latency read response delay line; tag/data only move with a valid
// entry so the outputs hold their last value between responses.
module ext_mem_resp_pipe #(
  parameter int LATENCY   = 4,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vld_i,
  input  logic [TAG_BITS-1:0]  tag_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 vld_o,
  output logic [TAG_BITS-1:0]  tag_o,
  output logic [DATA_BITS-1:0] data_o
);
  logic                 vld_q  [LATENCY];
  logic [TAG_BITS-1:0]  tag_q  [LATENCY];
  logic [DATA_BITS-1:0] data_q [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) begin
        tag_q[0]  <= tag_i;
        data_q[0] <= data_i;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          tag_q[i]  <= tag_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign vld_o  = vld_q[LATENCY-1];
  assign tag_o  = tag_q[LATENCY-1];
  assign data_o = data_q[LATENCY-1];
endmodule

// File: rtl/ext_mem_model.sv
// Line-granular main-memory model: tagged reads return after LATENCY cycles,
// writes take a separate byte-masked data beat one or more cycles later.
module ext_mem_model import mem_pkg::*; #(
  parameter int DATA_BITS  = MEM_DATA_BITS,
  parameter int ADDR_BITS  = MEM_ADDR_BITS,
  parameter int TAG_BITS   = MEM_TAG_BITS,
  parameter int DEPTH_BITS = 14,
  parameter int LATENCY    = 4
) (
  input logic           clk,
  input logic           reset,
  ext_mem_model_if.slave mem
);
  localparam int NBYTES = DATA_BITS / 8;
  localparam int DEPTH  = 1 << DEPTH_BITS;

  logic [DATA_BITS-1:0]  ram [DEPTH];
  mem_state_e            state_q;
  logic [DEPTH_BITS-1:0] widx_q;
  logic [DEPTH_BITS-1:0] ridx;
  logic                  rd_fire, wr_fire, wdata_fire;
  logic                  unused_addr_hi;

  function automatic logic [DATA_BITS-1:0] merge_bytes(
    input logic [DATA_BITS-1:0] old_line,
    input logic [DATA_BITS-1:0] new_line,
    input logic [NBYTES-1:0]    be
  );
    logic [DATA_BITS-1:0] r;
    r = old_line;
    for (int i = 0; i < NBYTES; i++)
      if (be[i]) r[8*i +: 8] = new_line[8*i +: 8];
    return r;
  endfunction

  // Upper address bits alias onto the stored lines.
  assign ridx           = mem.mem_req_addr[DEPTH_BITS-1:0];
  assign unused_addr_hi = ^mem.mem_req_addr[ADDR_BITS-1:DEPTH_BITS];

  assign mem.mem_req_ready      = !reset && (state_q == IDLE);
  assign mem.mem_req_data_ready = !reset && (state_q == WDATA);

  assign rd_fire    = mem.mem_req_valid && mem.mem_req_ready && !mem.mem_req_rw;
  assign wr_fire    = mem.mem_req_valid && mem.mem_req_ready &&  mem.mem_req_rw;
  assign wdata_fire = mem.mem_req_data_valid && mem.mem_req_data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      widx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (wr_fire) begin
          widx_q  <= ridx;
          state_q <= WDATA;
        end
        WDATA: if (wdata_fire) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a write in flight is dropped because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (wdata_fire)
      ram[widx_q] <= merge_bytes(ram[widx_q], mem.mem_req_data_bits, mem.mem_req_data_mask);
  end

  ext_mem_resp_pipe #(
    .LATENCY   (LATENCY),
    .TAG_BITS  (TAG_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_resp_pipe (
    .clk    (clk),
    .reset  (reset),
    .vld_i  (rd_fire),
    .tag_i  (mem.mem_req_tag),
    .data_i (ram[ridx]),
    .vld_o  (mem.mem_resp_valid),
    .tag_o  (mem.mem_resp_tag),
    .data_o (mem.mem_resp_data)
  );
endmodule

// File: tb/tb_ext_mem_model.sv
// Scoreboard bench for ext_mem_model: reads push expected tag/data/cycle,
// a monitor pops and compares every response.
module tb_ext_mem_model;
  localparam int LAT = 4;
  localparam logic [127:0] ONE  = 128'd1;
  localparam logic [127:0] ZERO = 128'd0;
  localparam logic [127:0] D1 = 128'h00112233_44556677_8899aabb_ccddeeff;

  typedef struct {
    logic [4:0]   tag;
    logic [127:0] data;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_n = 0;
  exp_t sbq [$];
  logic [127:0] model [int];

  ext_mem_model_if mem ();

  ext_mem_model #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_rd(input logic [27:0] a);
    int idx = int'(a[13:0]);
    return model.exists(idx) ? model[idx] : ZERO;
  endfunction

  function automatic logic [127:0] model_merge(input logic [127:0] o, input logic [127:0] n,
                                               input logic [15:0] m);
    logic [127:0] r = o;
    for (int b = 0; b < 128; b++)
      if (m[b/8]) r[b] = n[b];
    return r;
  endfunction

  // Response monitor: samples 1 time unit after every rising edge.
  initial begin
    logic [4:0]   last_tag  = '0;
    logic [127:0] last_data = '0;
    exp_t e;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (reset) begin
        last_tag  = '0;
        last_data = '0;
      end else begin
        while (sbq.size() > 0 && sbq[0].due < edge_n) begin
          chk("resp_missing", 128'(edge_n), 128'(sbq[0].due));
          void'(sbq.pop_front());
        end
        if (mem.mem_resp_valid) begin
          if (sbq.size() == 0) chk("resp_unexpected", ONE, ZERO);
          else begin
            e = sbq.pop_front();
            chk("resp_tag", 128'(mem.mem_resp_tag), 128'(e.tag));
            chk("resp_data", mem.mem_resp_data, e.data);
            chk("resp_cycle", 128'(edge_n), 128'(e.due));
          end
          last_tag  = mem.mem_resp_tag;
          last_data = mem.mem_resp_data;
        end else begin
          chk("hold_tag", 128'(mem.mem_resp_tag), 128'(last_tag));
          chk("hold_data", mem.mem_resp_data, last_data);
        end
      end
    end
  end

  task automatic req_idle();
    mem.mem_req_valid      = 1'b0;
    mem.mem_req_rw         = 1'b0;
    mem.mem_req_data_valid = 1'b0;
  endtask

  task automatic do_read(input logic [27:0] a, input logic [4:0] t);
    int waited = 0;
    mem.mem_req_valid = 1'b1;
    mem.mem_req_rw    = 1'b0;
    mem.mem_req_addr  = a;
    mem.mem_req_tag   = t;
    while (!mem.mem_req_ready && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!mem.mem_req_ready) begin
      chk("rd_accept_timeout", ZERO, ONE);
      return;
    end
    sbq.push_back('{tag: t, data: model_rd(a), due: edge_n + LAT});
    @(posedge clk); #2;
  endtask

  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m,
                          input int stall, input bit hold_rd,
                          input logic [27:0] ra, input logic [4:0] rt);
    int waited = 0;
    int idx = int'(a[13:0]);
    mem.mem_req_valid = 1'b1;
    mem.mem_req_rw    = 1'b1;
    mem.mem_req_addr  = a;
    while (!mem.mem_req_ready && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!mem.mem_req_ready) begin
      chk("wr_accept_timeout", ZERO, ONE);
      return;
    end
    @(posedge clk); #2;
    if (hold_rd) begin
      mem.mem_req_rw   = 1'b0;
      mem.mem_req_addr = ra;
      mem.mem_req_tag  = rt;
    end else mem.mem_req_valid = 1'b0;
    repeat (stall) begin
      chk("wr_stall_ready", 128'(mem.mem_req_ready), ZERO);
      chk("wr_stall_dready", 128'(mem.mem_req_data_ready), ONE);
      @(posedge clk); #2;
    end
    chk("wr_wait_ready", 128'(mem.mem_req_ready), ZERO);
    chk("wr_wait_dready", 128'(mem.mem_req_data_ready), ONE);
    mem.mem_req_data_valid = 1'b1;
    mem.mem_req_data_bits  = d;
    mem.mem_req_data_mask  = m;
    @(posedge clk); #2;
    mem.mem_req_data_valid = 1'b0;
    model[idx] = model_merge(model_rd(a), d, m);
    chk("wr_done_ready", 128'(mem.mem_req_ready), ONE);
    chk("wr_done_dready", 128'(mem.mem_req_data_ready), ZERO);
  endtask

  task automatic settle();
    req_idle();
    repeat (LAT + 2) begin @(posedge clk); #2; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_idle();
    mem.mem_req_addr      = '0;
    mem.mem_req_tag       = '0;
    mem.mem_req_data_bits = '0;
    mem.mem_req_data_mask = '0;
    @(posedge clk); #2;
    chk("rst_ready", 128'(mem.mem_req_ready), ZERO);
    chk("rst_dready", 128'(mem.mem_req_data_ready), ZERO);
    chk("rst_valid", 128'(mem.mem_resp_valid), ZERO);
    chk("rst_tag", 128'(mem.mem_resp_tag), ZERO);
    chk("rst_data", mem.mem_resp_data, ZERO);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_ready", 128'(mem.mem_req_ready), ONE);

    // single read, ready stays high
    do_write(28'h10, D1, 16'hFFFF, 0, 1'b0, '0, '0);
    do_read(28'h10, 5'd5);
    chk("rd_ready_held", 128'(mem.mem_req_ready), ONE);
    settle();

    // data beat in IDLE must not be consumed
    chk("idle_dready", 128'(mem.mem_req_data_ready), ZERO);
    mem.mem_req_data_valid = 1'b1;
    mem.mem_req_data_bits  = '1;
    mem.mem_req_data_mask  = '1;
    @(posedge clk); #2;
    mem.mem_req_data_valid = 1'b0;
    chk("idle_beat_ignored", dut.ram[16], D1);

    // partial byte mask
    do_write(28'h20, ZERO, 16'hFFFF, 0, 1'b0, '0, '0);
    do_write(28'h20, '1, 16'h000F, 0, 1'b0, '0, '0);
    chk("mask_ram", dut.ram[32], 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    do_read(28'h20, 5'd7);
    settle();

    // back-to-back reads
    for (int i = 1; i <= 3; i++)
      do_write(28'(i), {4{32'hC0DE0000 + 32'(i)}}, 16'hFFFF, 0, 1'b0, '0, '0);
    do_read(28'd1, 5'd1);
    do_read(28'd2, 5'd2);
    do_read(28'd3, 5'd3);
    settle();

    // stalled write data with a read waiting behind it
    do_write(28'h30, ZERO, 16'hFFFF, 0, 1'b0, '0, '0);
    do_write(28'h30, {8{16'hA55A}}, 16'hF0F0, 3, 1'b1, 28'h30, 5'd9);
    do_read(28'h30, 5'd9);
    settle();

    // address wrap modulo depth
    do_write(28'h4007, 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D, 16'hFFFF, 0, 1'b0, '0, '0);
    do_read(28'h7, 5'd12);
    settle();

    // reset with reads in flight and a write waiting for data
    do_write(28'h40, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'hFFFF, 0, 1'b0, '0, '0);
    do_read(28'd1, 5'd21);
    do_read(28'd2, 5'd22);
    mem.mem_req_rw   = 1'b1;
    mem.mem_req_addr = 28'h40;
    @(posedge clk); #2;
    mem.mem_req_valid = 1'b0;
    chk("pre_rst_dready", 128'(mem.mem_req_data_ready), ONE);
    mem.mem_req_data_valid = 1'b1;
    mem.mem_req_data_bits  = '0;
    mem.mem_req_data_mask  = '1;
    reset = 1'b1;
    sbq.delete();
    #1;
    chk("mid_rst_valid", 128'(mem.mem_resp_valid), ZERO);
    chk("mid_rst_tag", 128'(mem.mem_resp_tag), ZERO);
    chk("mid_rst_data", mem.mem_resp_data, ZERO);
    chk("mid_rst_ready", 128'(mem.mem_req_ready), ZERO);
    chk("mid_rst_dready", 128'(mem.mem_req_data_ready), ZERO);
    @(posedge clk); #1;
    mem.mem_req_data_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (LAT + 4) begin @(posedge clk); #2; end
    chk("rst_ram_kept", dut.ram[64], 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    chk("rst_after_ready", 128'(mem.mem_req_ready), ONE);
    chk("rst_after_dready", 128'(mem.mem_req_data_ready), ZERO);
    chk("sb_empty", 128'(sbq.size()), ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ext_mem_model.md
Name: ext_mem_model

Overview:
- Behavioural/synthesizable main-memory model that sits behind the processor's cache memory system on the external memory port.
- Accepts tagged line-granular read and write requests over a valid/ready request channel and a separate write-data channel.
- Returns tagged read data after a fixed latency on a response channel that has no backpressure.
- Storage array is named ram (one entry per line) so benches can preload it with $readmemh and peek at it.

Parameters:
- DATA_BITS, 128, line/beat width in bits (MEM_DATA_BITS)
- ADDR_BITS, 28, request line-address width (MEM_ADDR_BITS; byte address = addr<<4)
- TAG_BITS, 5, request/response tag width (MEM_TAG_BITS)
- DEPTH_BITS, 14, log2 of lines actually stored (16K lines = 256 KiB)
- LATENCY, 4, cycles from read acceptance to mem_resp_valid (must be >= 1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  request valid
- mem_req_ready  out  1  model can accept a request
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_addr  in  ADDR_BITS  line address
- mem_req_tag  in  TAG_BITS  request tag
- mem_req_data_valid  in  1  write data valid
- mem_req_data_ready  out  1  model can accept write data
- mem_req_data_bits  in  DATA_BITS  write data
- mem_req_data_mask  in  DATA_BITS/8  byte enables (bit i covers bits 8i+7:8i)
- mem_resp_valid  out  1  read response valid (no ready; consumer must always sink)
- mem_resp_tag  out  TAG_BITS  tag of the responding read
- mem_resp_data  out  DATA_BITS  read line data

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). While reset is high:
  - mem_req_ready=0, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0.
  - Response pipeline cleared; FSM forced to IDLE.
  - ram contents are NOT cleared.
- Index: ram[mem_req_addr[DEPTH_BITS-1:0]]. Higher address bits are ignored, so addresses wrap modulo depth.
- FSM states: IDLE and WDATA.
- IDLE:
  - mem_req_ready=1, mem_req_data_ready=0.
  - Request fires when mem_req_valid && mem_req_ready at a posedge.
  - Read fire: ram line sampled that cycle; {valid, tag, data} enters a LATENCY-deep shift pipeline. State stays IDLE, so one read can be accepted per cycle.
  - Write fire: latch the index and go to WDATA.
- WDATA:
  - mem_req_ready=0, mem_req_data_ready=1.
  - On mem_req_data_valid at a posedge, write each byte i of ram[index] from mem_req_data_bits where mask[i]=1. Unmasked bytes keep their old value.
  - Return to IDLE next cycle.
  - Write data is never accepted in the same cycle as its request.
  - Data beats arriving in IDLE are ignored (not consumed).
- Read timing: a read accepted at posedge t gives mem_resp_valid=1 during the cycle after posedge t+LATENCY-1. With LATENCY=1 that is the cycle immediately after acceptance. mem_resp_tag and mem_resp_data come from the same pipeline entry.
- Ordering: responses are returned in request order, and each tag is echoed unchanged.
- Read-after-write: because the write completes before the next request can fire, a later read always returns the merged data.
- Pipeline behaviour:
  - Outputs are registered (the last pipeline stage).
  - When no read is in flight, mem_resp_valid=0; mem_resp_data and mem_resp_tag hold their last value.
  - Reads already in flight keep advancing while the FSM is in WDATA.
- Reset mid-operation:
  - A pending write is dropped with no ram update.
  - In-flight reads are discarded and are never returned.
- Unknown or X inputs while a handshake signal is low are ignored.

Decomposition:
- Shared package (mem_pkg) holds MEM_DATA_BITS=128, MEM_ADDR_BITS=28, MEM_TAG_BITS=5 and the IDLE/WDATA state enum, shared with riscv_top's memory subsystem.
- One natural sub-module: ext_mem_resp_pipe, a parameterized LATENCY-deep valid/tag/data shift register with async clear.

Test Plan:
- Preload ram[0x10]=0x00112233_44556677_8899aabb_ccddeeff; read addr 0x10, tag 5 -> mem_resp_valid exactly LATENCY cycles later with that data and tag 5; mem_req_ready stays 1.
- Write addr 0x20, then data 0xFFFF...FF with mask 0x000F over a preloaded 0; read 0x20 -> 0x0000..._FFFFFFFF. Check mem_req_ready=0 and mem_req_data_ready=1 until the data beat is accepted.
- Back-to-back reads of addrs 1,2,3 with tags 1,2,3 on consecutive cycles -> three consecutive responses, in order, with matching tags and data.
- Write data stalled: assert data_valid 3 cycles after the write request -> mem_req_ready held 0 for those cycles; a read issued meanwhile is not accepted until after the write.
- Address wrap: write addr (1<<DEPTH_BITS)|7, then read addr 7 -> returns the written data.
- Assert reset with 2 reads in flight and a write in WDATA -> outputs go to 0 immediately (async); after release no response appears and ram is unchanged.
